ysyx_23060124_dmem_responder: RTL and testbench

- Memory-side responder for the core's load/store unit: accepts one load or store request at a time over a valid/ready request channel.
- Performs the access on an internal word-organised data memory after a programmable latency.
- Returns the result over a valid/ready response channel.
- Replaces the DPI pmem path in synthesisable/FPGA builds and serves as the latency-injecting memory model for LSU verification.

---
 rtl/ysyx_23060124_dmem_responder_pkg.sv | 12 +
 rtl/ysyx_23060124_dmem_bytearray.sv | 22 ++
 rtl/ysyx_23060124_dmem_responder.sv | 87 ++++++++
 tb/tb_ysyx_23060124_dmem_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060124_dmem_responder_pkg.sv
// ysyx_23060124_dmem_responder_pkg: shared size/state encodings and lane helpers for the dmem responder
package ysyx_23060124_dmem_responder_pkg;
  typedef enum logic [1:0] {LSU_SIZE_B = 2'd0, LSU_SIZE_H = 2'd1, LSU_SIZE_W = 2'd2} lsu_size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_e;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] lane);
    return size == LSU_SIZE_B ? 4'b0001 << lane : size == LSU_SIZE_H ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic size_err(input logic [1:0] size, input logic [1:0] lane);
    return size == 2'd3 || (size == LSU_SIZE_H && lane[0]) || (size == LSU_SIZE_W && lane != 2'd0);
  endfunction
endpackage

// File: rtl/ysyx_23060124_dmem_bytearray.sv
// ysyx_23060124_dmem_bytearray: four byte lanes, lane-enabled sync write and sync word read
module ysyx_23060124_dmem_bytearray #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic             re,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd;
    always_ff @(posedge clk) begin
      if (we[l]) mem[addr] <= wdata[8*l +: 8];
      if (re) rd <= mem[addr];
    end
    assign rdata[8*l +: 8] = rd;
  end
endmodule

// File: rtl/ysyx_23060124_dmem_responder.sv
// ysyx_23060124_dmem_responder: valid/ready load/store responder over a word memory with programmable latency
module ysyx_23060124_dmem_responder
  import ysyx_23060124_dmem_responder_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int              LATENCY   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int IDX_W = $clog2(DEPTH);
  resp_state_e st;
  logic wen_q, ld_ok, accept, commit, c_wen, c_err;
  logic [1:0] size_q, c_size;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr_q, c_addr, c_off;
  logic [DATA_W-1:0] wdata_q, c_wdata, word, shifted;
  assign req_ready = st == IDLE && !i_rst;
  assign accept = req_valid && req_ready;
  assign commit = (accept && LATENCY == 1) || (st == WAIT && cnt == 4'd0);
  // With LATENCY==1 the commit happens on the accept edge, so the live request is used directly
  assign c_wen = st == IDLE ? req_wen : wen_q;
  assign c_size = st == IDLE ? req_size : size_q;
  assign c_addr = st == IDLE ? req_addr : addr_q;
  assign c_wdata = st == IDLE ? req_wdata : wdata_q;
  assign c_off = c_addr - BASE_ADDR;
  assign c_err = c_addr < BASE_ADDR || (c_off >> 2) >= ADDR_W'(DEPTH) || size_err(c_size, c_addr[1:0]);
  ysyx_23060124_dmem_bytearray #(.DEPTH(DEPTH)) u_mem (
    .clk(i_clk),
    .we(commit && c_wen && !c_err ? lane_en(c_size, c_addr[1:0]) : 4'b0000),
    .re(commit),
    .addr(c_off[IDX_W+1:2]),
    .wdata(c_size == LSU_SIZE_B ? {4{c_wdata[7:0]}} : c_size == LSU_SIZE_H ? {2{c_wdata[15:0]}} : c_wdata),
    .rdata(word)
  );
  assign shifted = word >> {addr_q[1:0], 3'b000};
  assign resp_rdata = !ld_ok ? '0 : size_q == LSU_SIZE_B ? {24'b0, shifted[7:0]} :
                      size_q == LSU_SIZE_H ? {16'b0, shifted[15:0]} : shifted;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st <= IDLE;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      ld_ok <= 1'b0;
      cnt <= 4'd0;
      wen_q <= 1'b0;
      size_q <= 2'd0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        wen_q <= req_wen;
        size_q <= req_size;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        cnt <= 4'(LATENCY - 2);
        st <= WAIT;
      end
      if (st == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (commit) begin
        st <= RESP;
        resp_valid <= 1'b1;
        resp_err <= c_err;
        ld_ok <= !c_wen && !c_err;
      end
      if (resp_valid && resp_ready) begin
        st <= IDLE;
        resp_valid <= 1'b0;
        resp_err <= 1'b0;
        ld_ok <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_23060124_dmem_responder.sv
// tb_ysyx_23060124_dmem_responder: directed and scoreboarded checks of the responder at LATENCY 1 and 4
module tb_ysyx_23060124_dmem_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  logic i_clk = 0, i_rst = 1, sel = 0;
  logic req_valid = 0, req_wen = 0, resp_ready = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic rr1, rv1, re1, rr4, rv4, re4;
  logic [31:0] rd1, rd4;
  int n_chk = 0, n_err = 0;
  always #5 i_clk = ~i_clk;
  ysyx_23060124_dmem_responder #(.LATENCY(1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .req_valid(req_valid && !sel), .req_ready(rr1),
    .req_wen(req_wen), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_ready(resp_ready && !sel), .resp_rdata(rd1), .resp_err(re1)
  );
  ysyx_23060124_dmem_responder #(.LATENCY(4)) dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .req_valid(req_valid && sel), .req_ready(rr4),
    .req_wen(req_wen), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv4), .resp_ready(resp_ready && sel), .resp_rdata(rd4), .resp_err(re4)
  );
  assign req_ready = sel ? rr4 : rr1;
  assign resp_valid = sel ? rv4 : rv1;
  assign resp_rdata = sel ? rd4 : rd1;
  assign resp_err = sel ? re4 : re1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                     input int hold, input int gap, output logic [31:0] rd, output logic e, output int lat);
    int t;
    repeat (gap) step();
    req_valid = 1; req_wen = w; req_size = sz; req_addr = a; req_wdata = d;
    t = 0;
    while (!req_ready && t < 100) begin step(); t++; end
    if (t >= 100) chk("accept_timeout", 0, 1);
    step();
    req_valid = 0; req_wen = $urandom; req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      chk("busy_ready", req_ready, 0);
      step();
      lat++;
    end
    rd = resp_rdata;
    e = resp_err;
    repeat (hold) begin
      step();
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_err", resp_err, e);
      chk("hold_ready", req_ready, 0);
    end
    resp_ready = 1;
    chk("resp_ready_low", req_ready, 0);
    step();
    resp_ready = 0;
    chk("ready_after_hs", req_ready, 1);
    chk("valid_after_hs", resp_valid, 0);
  endtask
  logic [31:0] rd, sm [16];
  logic e;
  int lat;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #3;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    step(); step();
    i_rst = 0;
    step();
    chk("idle_ready", req_ready, 1);
    txn(1, 2, BASE + 32'h10, 32'hDEAD_BEEF, 0, 0, rd, e, lat);
    chk("st_w_lat", lat, 1); chk("st_w_rdata", rd, 0); chk("st_w_err", e, 0);
    txn(0, 2, BASE + 32'h10, 0, 0, 0, rd, e, lat);
    chk("ld_w_lat", lat, 1); chk("ld_w_rdata", rd, 32'hDEAD_BEEF); chk("ld_w_err", e, 0);
    txn(1, 0, BASE + 32'h13, 32'hFFFF_FF5A, 0, 1, rd, e, lat);
    chk("st_b_err", e, 0);
    txn(0, 1, BASE + 32'h12, 0, 1, 0, rd, e, lat);
    chk("ld_h_rdata", rd, 32'h0000_5AAD);
    txn(0, 0, BASE + 32'h11, 0, 0, 2, rd, e, lat);
    chk("ld_b_rdata", rd, 32'h0000_00BE);
    txn(0, 2, BASE + 32'h02, 0, 0, 0, rd, e, lat);
    chk("mis_w_err", e, 1); chk("mis_w_rdata", rd, 0);
    txn(1, 1, BASE + 32'h11, 32'h1234, 0, 0, rd, e, lat);
    chk("mis_h_err", e, 1); chk("mis_h_rdata", rd, 0);
    txn(0, 2, 32'h7FFF_FFFC, 0, 0, 0, rd, e, lat);
    chk("low_err", e, 1); chk("low_rdata", rd, 0);
    txn(0, 2, BASE + 32'h4000, 0, 0, 0, rd, e, lat);
    chk("high_err", e, 1); chk("high_rdata", rd, 0);
    txn(1, 3, BASE + 32'h10, 32'h0, 0, 0, rd, e, lat);
    chk("size3_err", e, 1);
    txn(0, 2, BASE + 32'h10, 0, 0, 0, rd, e, lat);
    chk("unchanged_rdata", rd, 32'h5AAD_BEEF); chk("unchanged_err", e, 0);
    sel = 1;
    txn(1, 2, BASE + 32'h40, 32'hCAFE_F00D, 0, 0, rd, e, lat);
    chk("l4_st_lat", lat, 4); chk("l4_st_err", e, 0);
    txn(0, 2, BASE + 32'h40, 0, 3, 0, rd, e, lat);
    chk("l4_ld_lat", lat, 4); chk("l4_ld_rdata", rd, 32'hCAFE_F00D);
    txn(0, 0, BASE + 32'h42, 0, 3, 0, rd, e, lat);
    chk("l4_ldb_rdata", rd, 32'h0000_00FE);
    txn(1, 2, BASE + 32'h20, 32'hAAAA_AAAA, 0, 0, rd, e, lat);
    req_valid = 1; req_wen = 1; req_size = 2; req_addr = BASE + 32'h20; req_wdata = 32'h1122_3344;
    step();
    req_valid = 0;
    step(); step();
    i_rst = 1;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_rdata", resp_rdata, 0);
    chk("mid_rst_err", resp_err, 0);
    step(); step(); step();
    i_rst = 0;
    step();
    txn(0, 2, BASE + 32'h20, 0, 0, 0, rd, e, lat);
    chk("dropped_store", rd, 32'hAAAA_AAAA);
    sel = 0;
    for (int i = 0; i < 16; i++) begin
      sm[i] = $urandom;
      txn(1, 2, BASE + 32'h100 + 32'(i * 4), sm[i], 0, 0, rd, e, lat);
    end
    for (int n = 0; n < 1000; n++) begin
      logic w, oob, xe;
      logic [1:0] sz, ln;
      logic [31:0] a, d, xr;
      int idx;
      w = 1'($urandom); sz = 2'($urandom_range(0, 3)); ln = 2'($urandom); d = $urandom;
      idx = $urandom_range(0, 15); oob = $urandom_range(0, 9) == 0;
      a = oob ? (w ? 32'h7FFF_FFF0 : BASE + 32'h4000) + 32'(ln) : BASE + 32'h100 + 32'(idx * 4) + 32'(ln);
      xe = oob || sz == 3 || (sz == 1 && ln[0]) || (sz == 2 && ln != 0);
      xr = 0;
      if (!xe)
        for (int b = 0; b < (1 << sz); b++)
          if (w) sm[idx][8*(ln+b) +: 8] = d[8*b +: 8];
          else xr[8*b +: 8] = sm[idx][8*(ln+b) +: 8];
      txn(w, sz, a, d, $urandom_range(0, 2), $urandom_range(0, 2), rd, e, lat);
      chk("rnd_rdata", rd, xr);
      chk("rnd_err", e, xe);
      chk("rnd_lat", lat, 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
